// File: rtl/vid_timing_pkg.sv
// vid_timing_pkg: 1080p timing constants, frame totals and the read-FSM state type
package vid_timing_pkg;
    localparam int H_ACTIVE_1080 = 1920;
    localparam int H_FP_1080     = 88;
    localparam int H_SYNC_1080   = 44;
    localparam int H_BP_1080     = 148;
    localparam int V_ACTIVE_1080 = 1080;
    localparam int V_FP_1080     = 4;
    localparam int V_SYNC_1080   = 5;
    localparam int V_BP_1080     = 36;

    typedef enum logic [1:0] {IDLE, WAIT_FILL, RUN} rd_state_e;

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL_1080 = line_total(H_ACTIVE_1080, H_FP_1080, H_SYNC_1080, H_BP_1080);
    localparam int V_TOTAL_1080 = line_total(V_ACTIVE_1080, V_FP_1080, V_SYNC_1080, V_BP_1080);
endpackage

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: free-running raster counters with stage-0 active/HS/VS decode
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_1080,
    parameter int H_FP     = H_FP_1080,
    parameter int H_SYNC   = H_SYNC_1080,
    parameter int H_BP     = H_BP_1080,
    parameter int V_ACTIVE = V_ACTIVE_1080,
    parameter int V_FP     = V_FP_1080,
    parameter int V_SYNC   = V_SYNC_1080,
    parameter int V_BP     = V_BP_1080
) (
    input  logic clk,
    input  logic rst_n,
    output logic active,
    output logic hs,
    output logic vs,
    output logic frame_start
);
    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_wrap;

    assign h_wrap = h_cnt == 12'(H_TOTAL - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 12'd1;
            if (h_wrap)
                v_cnt <= v_cnt == 11'(V_TOTAL - 1) ? '0 : v_cnt + 11'd1;
        end
    end

    assign active      = h_cnt < 12'(H_ACTIVE) && v_cnt < 11'(V_ACTIVE);
    assign hs          = h_cnt >= 12'(H_ACTIVE + H_FP) && h_cnt < 12'(H_ACTIVE + H_FP + H_SYNC);
    assign vs          = v_cnt >= 11'(V_ACTIVE + V_FP) && v_cnt < 11'(V_ACTIVE + V_FP + V_SYNC);
    assign frame_start = h_cnt == '0 && v_cnt == '0;
endmodule

// File: rtl/vid_fifo_rd_timing.sv
// vid_fifo_rd_timing: raster output stage that reads RGB565 pixels one cycle ahead from the line FIFO
module vid_fifo_rd_timing
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_1080,
    parameter int H_FP        = H_FP_1080,
    parameter int H_SYNC      = H_SYNC_1080,
    parameter int H_BP        = H_BP_1080,
    parameter int V_ACTIVE    = V_ACTIVE_1080,
    parameter int V_FP        = V_FP_1080,
    parameter int V_SYNC      = V_SYNC_1080,
    parameter int V_BP        = V_BP_1080,
    parameter bit SYNC_POL    = 1'b1,
    parameter int START_LEVEL = 1920
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] fifo_rd_data,
    input  logic        fifo_empty,
    input  logic [13:0] fifo_level,
    output logic        fifo_rd_en,
    output logic        vid_hs,
    output logic        vid_vs,
    output logic        vid_de,
    output logic [15:0] vid_data,
    output logic        underflow,
    input  logic        underflow_clr,
    output logic        streaming
);
    rd_state_e state, state_nxt;
    logic      active, hs, vs, frame_start, run_now, rd_q;

    vid_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk),
        .rst_n(rst_n),
        .active(active),
        .hs(hs),
        .vs(vs),
        .frame_start(frame_start)
    );

    // run_now acts on the boundary cycle itself so reading starts at (0,0) and stops cleanly at frame end
    always_comb begin
        run_now   = state == RUN ? !(frame_start && !enable)
                                 : state == WAIT_FILL && enable && frame_start && fifo_level >= 14'(START_LEVEL);
        state_nxt = run_now ? RUN : state == RUN ? IDLE : enable ? WAIT_FILL : IDLE;
    end

    assign fifo_rd_en = run_now && active && !fifo_empty;
    assign streaming  = state == RUN;
    assign vid_data   = rd_q ? fifo_rd_data : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            vid_hs    <= !SYNC_POL;
            vid_vs    <= !SYNC_POL;
            vid_de    <= 1'b0;
            rd_q      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            vid_hs    <= hs ~^ SYNC_POL;
            vid_vs    <= vs ~^ SYNC_POL;
            vid_de    <= active;
            rd_q      <= fifo_rd_en;
            underflow <= (run_now && active && fifo_empty) || (underflow && !underflow_clr);
        end
    end
endmodule

// File: tb/tb_vid_fifo_rd_timing.sv
// tb_vid_fifo_rd_timing: scoreboard bench on a reduced raster (14x7, 8x4 active) with a 1-cycle FIFO model
module tb_vid_fifo_rd_timing;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, underflow_clr = 1'b0, force_empty = 1'b0;
    logic [15:0] fifo_rd_data = '0;
    logic [13:0] fifo_level = '0;
    logic        q_empty = 1'b1;
    logic        fifo_empty, fifo_rd_en, vid_hs, vid_vs, vid_de, underflow, streaming;
    logic [15:0] vid_data;
    logic [15:0] fq[$];
    logic [15:0] exp_q[$];
    int          errors = 0, checks = 0;
    int          wr_req = 0, wr_cnt = 0, nreads = 0, de_cnt = 0;
    int          mh = 0, mv = 0, ph = 0, pv = 0;
    int          d0, r0;
    bit          prst = 1'b1, mon_en = 1'b0, rd_prev = 1'b0;

    always #5 clk = ~clk;

    vid_fifo_rd_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .START_LEVEL(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty),
        .fifo_level(fifo_level),
        .fifo_rd_en(fifo_rd_en),
        .vid_hs(vid_hs),
        .vid_vs(vid_vs),
        .vid_de(vid_de),
        .vid_data(vid_data),
        .underflow(underflow),
        .underflow_clr(underflow_clr),
        .streaming(streaming)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model with one-cycle read latency, plus a reference raster position (stage 0)
    assign fifo_empty = q_empty | force_empty;
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
            else fifo_rd_data <= 16'hdead;
            nreads <= nreads + 1;
        end
        while (wr_cnt < wr_req) begin
            fq.push_back(16'(wr_cnt));
            wr_cnt++;
        end
        fifo_level <= 14'(fq.size());
        q_empty    <= fq.size() == 0;
        prst <= !rst_n;
        ph   <= mh;
        pv   <= mv;
        if (!rst_n) begin
            mh <= 0;
            mv <= 0;
        end else begin
            mh <= mh == 13 ? 0 : mh + 1;
            if (mh == 13) mv <= mv == 6 ? 0 : mv + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("de", vid_de, !prst && ph < 8 && pv < 4);
            check("hs", vid_hs, !prst && ph >= 10 && ph < 12);
            check("vs", vid_vs, !prst && pv == 5);
            if (!rd_prev) check("blank_pix", vid_data, 0);
            else if (exp_q.size() == 0) check("sb_underrun", 1, 0);
            else check("pix", vid_data, exp_q.pop_front());
            de_cnt += int'(vid_de);
        end
        rd_prev = fifo_rd_en && rst_n;
    end

    task automatic push_pixels(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(16'(wr_req + i));
        wr_req += n;
    endtask

    task automatic wait_pos(input int h, input int v);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (mh == h && mv == v) return;
        end
        check("wait_pos_timeout", 0, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_de", vid_de, 0);
        check("rst_hs", vid_hs, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_stream", streaming, 0);
        rst_n = 1'b1;
        // idle raster: full frame of blank-data pixels, no reads
        wait_pos(0, 0);
        d0 = de_cnt;
        r0 = nreads;
        repeat (98) step();
        check("de_per_frame", de_cnt - d0, 32);
        check("reads_idle", nreads - r0, 0);
        check("idle_stream", streaming, 0);
        // frame A: 32 preloaded pixels streamed from (0,0)
        wait_pos(5, 0);
        push_pixels(32);
        enable = 1'b1;
        wait_pos(0, 0);
        check("pre_run_stream", streaming, 0);
        check("rd_at_h0", fifo_rd_en, 1);
        r0 = nreads;
        step();
        check("run_stream", streaming, 1);
        wait_pos(0, 2);
        push_pixels(32);
        // frame B: underflow, sticky flag, clear priority, then enable drop
        wait_pos(0, 0);
        check("reads_A", nreads - r0, 32);
        check("sb_level", exp_q.size(), 32);
        r0 = nreads;
        wait_pos(3, 1);
        force_empty = 1'b1;
        step();
        step();
        force_empty = 1'b0;
        check("uf_set", underflow, 1);
        repeat (3) step();
        check("uf_sticky", underflow, 1);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        check("uf_clr", underflow, 0);
        wait_pos(5, 2);
        force_empty = 1'b1;
        underflow_clr = 1'b1;
        step();
        force_empty = 1'b0;
        underflow_clr = 1'b0;
        check("uf_set_over_clr", underflow, 1);
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        check("uf_clr2", underflow, 0);
        wait_pos(0, 3);
        enable = 1'b0;
        wait_pos(0, 0);
        check("reads_B", nreads - r0, 29);
        check("stop_stream_hold", streaming, 1);
        check("stop_no_rd", fifo_rd_en, 0);
        step();
        check("stopped", streaming, 0);
        // frame C0: level 7 at boundary keeps WAIT_FILL; reaching 8 mid-frame starts next frame
        wait_pos(5, 0);
        push_pixels(4);
        enable = 1'b1;
        wait_pos(0, 0);
        check("wait_no_rd", fifo_rd_en, 0);
        step();
        check("hold_wait_fill", streaming, 0);
        wait_pos(5, 2);
        push_pixels(1);
        wait_pos(0, 0);
        r0 = nreads;
        step();
        check("run_after_fill", streaming, 1);
        wait_pos(0, 0);
        check("reads_C", nreads - r0, 8);
        check("uf_starve", underflow, 1);
        check("sb_drained", exp_q.size(), 0);
        // reset mid-line while HS and VS are asserted
        wait_pos(11, 5);
        check("pre_rst_hs", vid_hs, 1);
        check("pre_rst_vs", vid_vs, 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_hs", vid_hs, 0);
        check("mid_rst_vs", vid_vs, 0);
        check("mid_rst_de", vid_de, 0);
        check("mid_rst_data", vid_data, 0);
        check("mid_rst_uf", underflow, 0);
        check("mid_rst_stream", streaming, 0);
        check("mid_rst_rd_en", fifo_rd_en, 0);
        rst_n = 1'b1;
        step();
        check("restart_de", vid_de, 1);
        check("restart_data", vid_data, 0);
        repeat (20) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
